// File: rtl/junction_phase_scheduler.sv
// Two-road junction sequencer: eight fixed phases with per-phase dwell timers,
// a latched pedestrian walk served in the all-red phases, and per-road emergency pre-emption.
module junction_phase_scheduler #(
  parameter int TW       = 8,
  parameter int T_ALLRED = 4,
  parameter int T_RY     = 3,
  parameter int T_GREEN  = 20,
  parameter int T_GY     = 5,
  parameter int T_WALK   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       emg_ns,
  input  logic       emg_ew,
  output logic [2:0] phase,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_pending
);

  typedef enum logic [2:0] {
    AR_A  = 3'd0,
    NS_RY = 3'd1,
    NS_G  = 3'd2,
    NS_GY = 3'd3,
    AR_B  = 3'd4,
    EW_RY = 3'd5,
    EW_G  = 3'd6,
    EW_GY = 3'd7
  } phase_t;

  localparam logic [TW-1:0] LD_ALLRED = TW'(T_ALLRED - 1);
  localparam logic [TW-1:0] LD_RY     = TW'(T_RY - 1);
  localparam logic [TW-1:0] LD_GREEN  = TW'(T_GREEN - 1);
  localparam logic [TW-1:0] LD_GY     = TW'(T_GY - 1);
  localparam logic [TW-1:0] LD_WALK   = TW'(T_WALK - 1);

  phase_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          walk_d, ped_d, advance, emg_ew_eff;
  logic          ns_red_d, ns_yellow_d, ns_green_d;
  logic          ew_red_d, ew_yellow_d, ew_green_d;

  assign phase = state_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q - TW'(1);
    walk_d     = walk;
    ped_d      = ped_pending | ped_req;
    advance    = 1'b0;
    emg_ew_eff = emg_ew & ~emg_ns;

    // The served road's green is held; the conflicting road's go phases are cut short.
    case (state_q)
      NS_RY: begin
        if (emg_ew_eff) begin
          state_d = NS_GY;
          timer_d = LD_GY;
        end else advance = (timer_q == '0);
      end
      NS_G: begin
        if (emg_ns) timer_d = timer_q;
        else if (emg_ew_eff) begin
          state_d = NS_GY;
          timer_d = LD_GY;
        end else advance = (timer_q == '0);
      end
      EW_RY: begin
        if (emg_ns) begin
          state_d = EW_GY;
          timer_d = LD_GY;
        end else advance = (timer_q == '0);
      end
      EW_G: begin
        if (emg_ns) begin
          state_d = EW_GY;
          timer_d = LD_GY;
        end else if (emg_ew_eff) timer_d = timer_q;
        else advance = (timer_q == '0);
      end
      default: advance = (timer_q == '0);
    endcase

    if (advance) begin
      state_d = phase_t'(state_q + 3'd1);
      walk_d  = 1'b0;
      case (state_d)
        AR_A, AR_B: begin
          // A walk is only granted when no pre-emption is in progress.
          if ((ped_pending | ped_req) && !(emg_ns | emg_ew)) begin
            timer_d = LD_WALK;
            walk_d  = 1'b1;
            ped_d   = 1'b0;
          end else timer_d = LD_ALLRED;
        end
        NS_RY, EW_RY: timer_d = LD_RY;
        NS_G, EW_G:   timer_d = LD_GREEN;
        default:      timer_d = LD_GY;
      endcase
    end

    ns_red_d    = !(state_d == NS_G || state_d == NS_GY);
    ns_yellow_d = (state_d == NS_RY || state_d == NS_GY);
    ns_green_d  = (state_d == NS_G || state_d == NS_GY);
    ew_red_d    = !(state_d == EW_G || state_d == EW_GY);
    ew_yellow_d = (state_d == EW_RY || state_d == EW_GY);
    ew_green_d  = (state_d == EW_G || state_d == EW_GY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= AR_A;
      timer_q     <= LD_ALLRED;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
      ns_red      <= 1'b1;
      ns_yellow   <= 1'b0;
      ns_green    <= 1'b0;
      ew_red      <= 1'b1;
      ew_yellow   <= 1'b0;
      ew_green    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      walk        <= walk_d;
      ped_pending <= ped_d;
      ns_red      <= ns_red_d;
      ns_yellow   <= ns_yellow_d;
      ns_green    <= ns_green_d;
      ew_red      <= ew_red_d;
      ew_yellow   <= ew_yellow_d;
      ew_green    <= ew_green_d;
    end
  end

endmodule
